alu_operand_sequencer: RTL and testbench

- Initiator side of the 64-bit ALU datapath interface: buffers operation commands, drives the ALU operand and opcode lines, waits a fixed ALU latency, captures the result and returns it over a valid/ready result port.
- Sits between the register-read stage and the combinational ALU units (AND/OR/XOR/ADD), which have no handshake of their own.
- Commands are processed strictly in order, one at a time.

---
 rtl/alu_operand_sequencer.sv | 130 +++++++++++++
 tb/tb_alu_operand_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: in-order command FIFO driving a fixed-latency ALU, result over valid/ready; define ALU_SELFCHECK_EN for the chk_err result checker
module alu_operand_sequencer #(
  parameter int DATA_WIDTH = 64,
  parameter int OP_WIDTH = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [OP_WIDTH-1:0]   cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [OP_WIDTH-1:0]   alu_op,
  input  logic [DATA_WIDTH-1:0] alu_s,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [OP_WIDTH-1:0]   res_op,
  output logic                  busy,
  output logic [31:0]           op_count,
  output logic                  chk_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(ALU_LAT + 1);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] fifo_a_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_b_q [FIFO_DEPTH];
  logic [OP_WIDTH-1:0] fifo_op_q [FIFO_DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, res_data_q, res_data_d;
  logic [OP_WIDTH-1:0] alu_op_q, alu_op_d, res_op_q, res_op_d;
  logic res_valid_q, res_valid_d;
  logic [31:0] op_count_q, op_count_d;
  logic empty, full, push, pop, sample;
  logic [DATA_WIDTH-1:0] head_a, head_b;
  logic [OP_WIDTH-1:0] head_op;
  assign empty = wr_q == rd_q;
  assign full = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
  assign push = cmd_valid && !full;
  assign pop = state_q == S_IDLE && !empty;
  assign sample = state_q == S_WAIT && cnt_q == CW'(1);
  assign head_a = fifo_a_q[rd_q[AW-1:0]];
  assign head_b = fifo_b_q[rd_q[AW-1:0]];
  assign head_op = fifo_op_q[rd_q[AW-1:0]];
  always_comb begin
    wr_d = push ? wr_q + (AW+1)'(1) : wr_q;
    rd_d = pop ? rd_q + (AW+1)'(1) : rd_q;
    alu_a_d = pop ? head_a : alu_a_q;
    alu_b_d = pop ? head_b : alu_b_q;
    alu_op_d = pop ? head_op : alu_op_q;
    cnt_d = pop ? CW'(ALU_LAT) : state_q == S_WAIT ? cnt_q - CW'(1) : cnt_q;
    res_data_d = sample ? alu_s : res_data_q;
    res_op_d = sample ? alu_op_q : res_op_q;
    res_valid_d = sample ? 1'b1 : (state_q == S_HOLD && res_ready) ? 1'b0 : res_valid_q;
    op_count_d = (state_q == S_HOLD && res_ready) ? op_count_q + 32'd1 : op_count_q;
    state_d = pop ? S_WAIT : sample ? S_HOLD : (state_q == S_HOLD && res_ready) ? S_IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a_q[wr_q[AW-1:0]] <= cmd_a;
      fifo_b_q[wr_q[AW-1:0]] <= cmd_b;
      fifo_op_q[wr_q[AW-1:0]] <= cmd_op;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      alu_op_q <= '0;
      res_data_q <= '0;
      res_op_q <= '0;
      res_valid_q <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      alu_op_q <= alu_op_d;
      res_data_q <= res_data_d;
      res_op_q <= res_op_d;
      res_valid_q <= res_valid_d;
      op_count_q <= op_count_d;
    end
  end
`ifdef ALU_SELFCHECK_EN
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic chk_err_q, chk_err_d;
  always_comb begin
    exp_d = !pop ? exp_q :
            head_op == OP_WIDTH'(0) ? head_a & head_b :
            head_op == OP_WIDTH'(1) ? head_a | head_b :
            head_op == OP_WIDTH'(2) ? head_a ^ head_b : head_a + head_b;
    chk_err_d = chk_err_q || (sample && alu_s != exp_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q <= '0;
      chk_err_q <= 1'b0;
    end else begin
      exp_q <= exp_d;
      chk_err_q <= chk_err_d;
    end
  end
  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif
  assign cmd_ready = !full;
  assign alu_a = alu_a_q;
  assign alu_b = alu_b_q;
  assign alu_op = alu_op_q;
  assign res_valid = res_valid_q;
  assign res_data = res_data_q;
  assign res_op = res_op_q;
  assign busy = state_q != S_IDLE || !empty;
  assign op_count = op_count_q;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: queue-based reference model plus directed and random stimulus for alu_operand_sequencer
module tb_alu_operand_sequencer;
  localparam int DEPTH = 4;
`ifdef ALU_SELFCHECK_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0, res_ready = 1'b1, bad_alu = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [63:0] cmd_a = '0, cmd_b = '0;
  logic cmd_ready, res_valid, busy, chk_err;
  logic [63:0] alu_a, alu_b, alu_s, res_data;
  logic [1:0] alu_op, res_op;
  logic [31:0] op_count;
  logic cmd_ready3, res_valid3, busy3, chk_err3;
  logic [63:0] alu_a3, alu_b3, alu_s3, res_data3, p1, p2;
  logic [1:0] alu_op3, res_op3;
  logic [31:0] op_count3;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  function automatic logic [63:0] f(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    return op == 2'd0 ? a & b : op == 2'd1 ? a | b : op == 2'd2 ? a ^ b : a + b;
  endfunction
  assign alu_s = f(alu_op, alu_a, alu_b) ^ {63'b0, bad_alu};
  always @(posedge clk) begin
    p1 <= f(alu_op3, alu_a3, alu_b3);
    p2 <= p1;
  end
  assign alu_s3 = p2;
  alu_operand_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_s(alu_s),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_op(res_op),
    .busy(busy), .op_count(op_count), .chk_err(chk_err)
  );
  alu_operand_sequencer #(.ALU_LAT(3)) u3 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready3), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3), .alu_s(alu_s3),
    .res_valid(res_valid3), .res_ready(res_ready), .res_data(res_data3), .res_op(res_op3),
    .busy(busy3), .op_count(op_count3), .chk_err(chk_err3)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask
  logic [129:0] q[$];
  int m_left = 0;
  bit m_hold = 0, m_err = 0, started = 0;
  logic [63:0] m_a = '0, m_b = '0, m_rd = '0;
  logic [1:0] m_op = '0, m_rop = '0;
  logic [31:0] m_cnt = '0;
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_left = 0; m_hold = 0; m_err = 0;
      m_a = '0; m_b = '0; m_op = '0; m_rd = '0; m_rop = '0; m_cnt = '0;
      started = 1;
    end else begin
      automatic bit pop = !m_hold && m_left == 0 && q.size() > 0;
      automatic bit push = cmd_valid && q.size() < DEPTH;
      if (m_hold && res_ready) begin
        m_hold = 0;
        m_cnt = m_cnt + 32'd1;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_rd = f(m_op, m_a, m_b) ^ {63'b0, bad_alu};
          m_rop = m_op;
          m_hold = 1;
          if (bad_alu) m_err = SC;
        end
      end
      if (pop) begin
        {m_op, m_a, m_b} = q.pop_front();
        m_left = 1;
      end
      if (push) q.push_back({cmd_op, cmd_a, cmd_b});
    end
  end
  always @(negedge clk) begin
    if (started) begin
      chk("cmd_ready", cmd_ready, q.size() < DEPTH);
      chk("res_valid", res_valid, m_hold);
      chk("res_data", res_data, m_rd);
      chk("res_op", res_op, m_rop);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_op", alu_op, m_op);
      chk("busy", busy, m_hold || m_left > 0 || q.size() > 0);
      chk("op_count", op_count, m_cnt);
      chk("chk_err", chk_err, m_err);
    end
  end
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    cyc(1);
    cmd_valid = 1'b0;
  endtask
  initial begin
    int n;
    cyc(2);
    reset = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_chk_err", chk_err, 0);
    send(2'd0, 64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F);
    chk("t1_valid_e0", res_valid, 0);
    cyc(1);
    chk("t1_valid_e1", res_valid, 0);
    chk("t1_issue_a", alu_a, 64'hFFFF0000FFFF0000);
    cyc(1);
    chk("t1_valid_e2", res_valid, 1);
    chk("t1_data", res_data, 64'h0F0F00000F0F0000);
    chk("t1_op", res_op, 0);
    cyc(1);
    chk("t1_count", op_count, 1);
    cyc(4);
    send(2'd3, 64'hFFFFFFFFFFFFFFFF, 64'd1);
    cyc(1);
    chk("t3_issue_op", alu_op3, 3);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk("t3_lat_valid", res_valid3, k == 2);
    end
    chk("t3_data", res_data3, 0);
    chk("t3_op", res_op3, 3);
    cyc(2);
    res_ready = 1'b0;
    cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cmd_op = 2'($urandom_range(0, 3)); cmd_a = {$urandom, $urandom}; cmd_b = {$urandom, $urandom};
      cyc(1);
    end
    cmd_valid = 1'b0;
    chk("t2_full_ready", cmd_ready, 0);
    chk("t2_hold_valid", res_valid, 1);
    cyc(3);
    chk("t2_still_full", cmd_ready, 0);
    res_ready = 1'b1;
    n = 0;
    while (busy && n < 100) begin
      cyc(1);
      n++;
    end
    chk("t2_drained", busy, 0);
    chk("t2_count", op_count, 7);
    res_ready = 1'b0;
    cmd_valid = 1'b1;
    cyc(3);
    cmd_valid = 1'b0;
    chk("t4_hold", res_valid, 1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("t4_valid", res_valid, 0);
    chk("t4_ready", cmd_ready, 1);
    chk("t4_count", op_count, 0);
    chk("t4_alu_a", alu_a, 0);
    chk("t4_busy", busy, 0);
    res_ready = 1'b1;
    bad_alu = 1'b1;
    send(2'd2, 64'd5, 64'd5);
    cyc(2);
    chk("t5_data", res_data, 1);
    chk("t5_err", chk_err, SC);
    cyc(1);
    bad_alu = 1'b0;
    send(2'd1, 64'd1, 64'd2);
    cyc(2);
    chk("t5_good_data", res_data, 3);
    chk("t5_sticky", chk_err, SC);
    cyc(2);
    force dut.op_count_q = 32'hFFFFFFFF;
    m_cnt = 32'hFFFFFFFF;
    cyc(1);
    release dut.op_count_q;
    chk("t6_preload", op_count, 32'hFFFFFFFF);
    send(2'd3, 64'd7, 64'd9);
    cyc(3);
    chk("t6_wrap", op_count, 0);
    for (int k = 0; k < 3000; k++) begin
      cmd_valid = $urandom_range(0, 1) == 1;
      cmd_op = 2'($urandom_range(0, 3));
      cmd_a = {$urandom, $urandom};
      cmd_b = {$urandom, $urandom};
      res_ready = $urandom_range(0, 9) < 7;
      reset = $urandom_range(0, 299) == 0;
      cyc(1);
    end
    reset = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    cyc(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
